cla_seq_ctrl: RTL and testbench
===============================

CLA_SEQ_CTRL -- requirements
Module: cla_seq_ctrl

Interface
REQ-001 SHALL have parameter NIBBLES, default 4: number of 4-bit slices per operand; W = 4*NIBBLES; legal range 2..16.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operand request valid.
REQ-005 SHALL have port in_ready  output  1  controller can accept a request.
REQ-006 SHALL have port a  input  W  operand A.
REQ-007 SHALL have port b  input  W  operand B.
REQ-008 SHALL have port cin  input  1  carry-in.
REQ-009 SHALL have port op_sub  input  1  subtract request; honoured only per REQ-029.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port sum  output  W  result.
REQ-013 SHALL have port cout  output  1  carry-out of the most significant slice.
REQ-014 SHALL have port busy  output  1  high in ADD and DONE.

Function
REQ-015 SHALL implement FSM states IDLE, ADD, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-016 In IDLE, in_valid=1 SHALL latch a, b, cin (and op_sub) into internal registers, clear slice index to 0, load carry register with cin, and move to ADD on the same edge.
REQ-017 In ADD, each cycle SHALL compute one 4-bit slice (index i, bits 4i+3..4i) of latched A and B with the carry register using carry look-ahead: per-bit generate/propagate, all slice carries in two-level logic, no ripple within the slice.
REQ-018 Each ADD cycle SHALL write the slice sum into sum[4i+3:4i], load the carry register with the slice carry-out, and increment i.
REQ-019 When i = NIBBLES-1, the ADD cycle SHALL also load cout with the slice carry-out and move to DONE.
REQ-020 Latency SHALL be exactly NIBBLES cycles from the accepting edge to the first cycle with out_valid=1.
REQ-021 In DONE, sum, cout and out_valid SHALL hold stable until out_ready=1; the edge with out_ready=1 SHALL return to IDLE.
REQ-022 in_valid in DONE, including in the same cycle as out_ready, SHALL be ignored (in_ready=0); new accept is possible at the earliest one cycle after leaving DONE.
REQ-023 Input ports a, b, cin and op_sub changing after acceptance SHALL have no effect on the in-flight result.
REQ-024 The sum bits of slices not yet computed SHALL retain their previous values during ADD; only DONE values are architecturally valid.
REQ-025 Arithmetic SHALL be modulo 2^W; {cout,sum} = A + B + cin exactly.

Reset
REQ-026 rst_n = 0 SHALL immediately force state IDLE, slice index 0, carry register 0, sum 0, cout 0, out_valid 0, busy 0, in_ready 1 (after release).
REQ-027 Reset during ADD or DONE SHALL discard the operation; no out_valid SHALL be produced for it.

Configuration
REQ-028 Macro CLA_SEQ_SUB_EN SHALL select subtraction support.
REQ-029 With CLA_SEQ_SUB_EN defined, op_sub=1 at acceptance SHALL latch ~b in place of b and load carry register with 1 (cin ignored), giving sum = A - B mod 2^W, cout = 1 when A >= B (no borrow).
REQ-030 Without CLA_SEQ_SUB_EN, op_sub SHALL be ignored and every request is A + B + cin; no inversion logic SHALL be present.

Verification (NIBBLES=4)
REQ-031 a=16'h1234, b=16'h4321, cin=0 -> out_valid 4 cycles after accept, sum=16'h5555, cout=0.
REQ-032 a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1 (carry crosses every slice boundary).
REQ-033 a=16'h0000, b=16'hFFFF, cin=1 -> sum=16'h0000, cout=1; a=16'h8000, b=16'h8000, cin=0 -> sum=16'h0000, cout=1.
REQ-034 out_ready held 0 for 5 cycles in DONE with in_valid=1 -> sum/cout/out_valid unchanged, in_ready=0; after handshake, in_ready=1 next cycle and new request accepted.
REQ-035 rst_n pulsed low during the third ADD cycle -> out_valid=0, sum=0, cout=0, in_ready=1 after release; no result appears.
REQ-036 With CLA_SEQ_SUB_EN: a=16'h0005, b=16'h0007, op_sub=1 -> sum=16'hFFFE, cout=0; without the macro, same stimulus with cin=0 -> sum=16'h000C, cout=0.

Source files
------------

// File: rtl/cla_seq_ctrl.sv
// cla_seq_ctrl: sequential carry-look-ahead adder controller.
// Operands are latched on a valid/ready handshake. One 4-bit look-ahead slice
// is added per cycle, least significant first. The result is held with
// out_valid until the consumer accepts it.
// Optional feature: define CLA_SEQ_SUB_EN to honour op_sub (A - B).
module cla_seq_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4*NIBBLES-1:0] a,
   input  logic [4*NIBBLES-1:0] b,
   input  logic                 cin,
   input  logic                 op_sub,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4*NIBBLES-1:0] sum,
   output logic                 cout,
   output logic                 busy
);

   localparam int W     = 4 * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADD  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   logic [1:0]       state_q, state_d;
   logic [IDX_W-1:0] idx_q,   idx_d;
   logic             carry_q, carry_d;
   logic [W-1:0]     a_q,     a_d;
   logic [W-1:0]     b_q,     b_d;
   logic [W-1:0]     sum_q,   sum_d;
   logic             cout_q,  cout_d;

   // Operand B and carry-in as seen by the adder once a request is accepted.
   logic [W-1:0]     b_eff;
   logic             cin_eff;

   // Current slice operands and look-ahead terms.
   logic [3:0]       a_sl, b_sl;
   logic [3:0]       g, p;
   logic [4:0]       c;
   logic [3:0]       slice_sum;

`ifdef CLA_SEQ_SUB_EN
   // Subtraction is A + ~B + 1; the request carry-in is not used in that case.
   always_comb begin
      b_eff   = op_sub ? ~b : b;
      cin_eff = op_sub ? 1'b1 : cin;
   end
`else
   // Without subtraction support, op_sub has no effect at all.
   logic unused_op_sub;
   assign unused_op_sub = op_sub;

   // Plain addition path: operands pass straight through.
   always_comb begin
      b_eff   = b;
      cin_eff = cin;
   end
`endif

   // Select the slice addressed by the slice index from the latched operands.
   always_comb begin
      // NOTE: every combinational output gets a default first so that no path
      // leaves it unassigned, which would otherwise infer a latch.
      a_sl = 4'd0;
      b_sl = 4'd0;
      for (int i = 0; i < NIBBLES; i++) begin
         if (idx_q == IDX_W'(i)) begin
            a_sl = a_q[4*i +: 4];
            b_sl = b_q[4*i +: 4];
         end
      end
   end

   // Four-bit carry look-ahead: every carry is a flat sum of products of g/p
   // and the incoming carry, so nothing ripples inside the slice.
   always_comb begin
      g    = a_sl & b_sl;
      p    = a_sl ^ b_sl;
      c[0] = carry_q;
      c[1] = g[0] | (p[0] & c[0]);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & c[0]);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);
      slice_sum = p ^ c[3:0];
   end

   // Next-state logic: accept in IDLE, one slice per ADD cycle, hold in DONE.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b_eff;
               carry_d = cin_eff;
               idx_d   = '0;
               state_d = S_ADD;
            end
         end
         S_ADD: begin
            // Slices above the current index keep their previous contents.
            for (int i = 0; i < NIBBLES; i++) begin
               if (idx_q == IDX_W'(i)) begin
                  sum_d[4*i +: 4] = slice_sum;
               end
            end
            carry_d = c[4];
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               cout_d  = c[4];
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            // in_valid is deliberately ignored here, even alongside out_ready.
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers; reset discards any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the operand registers are reset too; they are only a few flops,
      // and this keeps their contents defined after reset.
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let every flop sample the values
         // from before the edge, independent of statement order.
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q == S_ADD) || (state_q == S_DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Self-checking bench for cla_seq_ctrl (NIBBLES=4). Expected results are
// pushed to a scoreboard queue at acceptance and popped when out_valid rises.
module tb_cla_seq_ctrl;

   localparam int NIB = 4;
   localparam int W   = 4 * NIB;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         op_sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum;
   logic         cout;
   logic         busy;

   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];

   cla_seq_ctrl #(.NIBBLES(NIB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .op_sub    (op_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Compare one observed value against its expectation.
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model of one request.
   function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic mc, input logic msub);
      logic [W:0] full;
      exp_t       r;
`ifdef CLA_SEQ_SUB_EN
      if (msub) full = {1'b0, ma} + {1'b0, ~mb} + (W+1)'(1);
      else      full = {1'b0, ma} + {1'b0, mb} + (W+1)'(mc);
`else
      full = {1'b0, ma} + {1'b0, mb} + (W+1)'(mc);
      if (msub) full = full;
`endif
      r.sum  = full[W-1:0];
      r.cout = full[W];
      return r;
   endfunction

   // Present a request for one edge in IDLE, then scramble the input ports.
   task automatic accept(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tc, input logic ts);
      check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
      a = ta; b = tb; cin = tc; op_sub = ts; in_valid = 1'b1;
      sb_q.push_back(model(ta, tb, tc, ts));
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); cin = ~tc; op_sub = ~ts;
      check("busy_in_add", {31'd0, busy}, 32'd1);
      check("in_ready_in_add", {31'd0, in_ready}, 32'd0);
   endtask

   // Wait (bounded) for out_valid, check latency and pop/compare the result.
   task automatic wait_result(input string tag);
      int   lat;
      exp_t e;
      lat = 1;
      @(posedge clk); #1;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_latency"}, lat, NIB);
      if (sb_q.size() > 0) e = sb_q.pop_front();
      else e = '0;
      check({tag, "_sum"}, {16'd0, sum}, {16'd0, e.sum});
      check({tag, "_cout"}, {31'd0, cout}, {31'd0, e.cout});
   endtask

   // Complete the output handshake and confirm return to IDLE.
   task automatic release_result(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_in_ready_after"}, {31'd0, in_ready}, 32'd1);
      check({tag, "_out_valid_after"}, {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      exp_t held;

      // Reset state.
      #12;
      check("rst_in_ready", {31'd0, in_ready}, 32'd0 + 32'(1'b0 == 1'b0));
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_sum", {16'd0, sum}, 32'd0);
      check("rst_cout", {31'd0, cout}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed additions.
      accept(16'h1234, 16'h4321, 1'b0, 1'b0);
      wait_result("add_1234");
      check("add_1234_const", {16'd0, sum}, 32'h5555);
      release_result("add_1234");

      accept(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      wait_result("carry_chain");
      release_result("carry_chain");

      accept(16'h0000, 16'hFFFF, 1'b1, 1'b0);
      wait_result("cin_chain");
      release_result("cin_chain");

      accept(16'h8000, 16'h8000, 1'b0, 1'b0);
      wait_result("msb_carry");
      release_result("msb_carry");

      // Hold in DONE with out_ready low and in_valid high.
      accept(16'h0F0F, 16'h00F1, 1'b1, 1'b0);
      held = model(16'h0F0F, 16'h00F1, 1'b1, 1'b0);
      wait_result("hold");
      a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("hold_sum", {16'd0, sum}, {16'd0, held.sum});
         check("hold_cout", {31'd0, cout}, {31'd0, held.cout});
         check("hold_out_valid", {31'd0, out_valid}, 32'd1);
         check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      // Handshake while in_valid stays high: that edge must not accept.
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("hs_in_ready", {31'd0, in_ready}, 32'd1);
      check("hs_busy", {31'd0, busy}, 32'd0);
      in_valid = 1'b0;
      accept(16'h1111, 16'h2222, 1'b0, 1'b0);
      wait_result("after_hold");
      release_result("after_hold");

      // Reset during the third ADD cycle discards the operation.
      accept(16'hABCD, 16'h1357, 1'b1, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #2;
      check("mid_rst_sum", {16'd0, sum}, 32'd0);
      check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_cout", {31'd0, cout}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      void'(sb_q.pop_back());
      @(posedge clk); #1;
      check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
      begin
         int seen;
         seen = 0;
         for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
         end
         check("post_rst_no_result", seen, 0);
      end

      // op_sub request: subtraction with the macro, plain addition without it.
      accept(16'h0005, 16'h0007, 1'b0, 1'b1);
      wait_result("sub");
`ifdef CLA_SEQ_SUB_EN
      check("sub_const", {16'd0, sum}, 32'hFFFE);
`else
      check("sub_const", {16'd0, sum}, 32'h000C);
`endif
      release_result("sub");

      // A few random additions through the scoreboard.
      for (int i = 0; i < 4; i++) begin
         accept(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
         wait_result("rand");
         release_result("rand");
      end

      check("sb_empty", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
